// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown control stage.
package timer_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned TICK_DIV_MIN = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Prescaler counter width for a given divide ratio (never below one bit).
  function automatic int unsigned cnt_width(input int unsigned div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into single-cycle tick pulses; the counter freezes whenever run is low.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter  int unsigned TICK_DIV = 50_000_000,
  localparam int unsigned CNT_W    = cnt_width(TICK_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             gate,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // Clear wins over run so a stop or load always restarts the period from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
    end
  end

  // gate lets the parent suppress the final tick once the chain already reads zero.
  assign tick = run && gate && (cnt == CNT_MAX);

endmodule

// File: rtl/countdown_ctrl.sv
// Sequences load, run, pause and expiry for a digitTimer chain and drives its tick.
module countdown_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       digits_zero,
  output logic       reconfig,
  output logic       enable,
  output logic       tick,
  output logic       expired,
  output logic       done,
  output logic [2:0] state
);

  localparam int unsigned CNT_W = cnt_width(TICK_DIV);

  if (TICK_DIV < TICK_DIV_MIN) begin : g_div_check
    $error("countdown_ctrl: TICK_DIV must be at least %0d", TICK_DIV_MIN);
  end

  state_t           state_q;
  state_t           state_d;
  logic             expired_d;
  logic             pre_clear;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request priority: stop, then start, then pause; start is ignored while running.
  always_comb begin
    state_d   = state_q;
    expired_d = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) state_d = ST_LOAD;
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (digits_zero) begin
            state_d = ST_DONE;
          end else if (pause) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: if (start) state_d = ST_RUN;
        ST_DONE: if (start) state_d = ST_LOAD;
        default: state_d = ST_IDLE;
      endcase
    end
    expired_d = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      reconfig <= 1'b0;
      enable   <= 1'b0;
      done     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      reconfig <= (state_d == ST_LOAD);
      enable   <= (state_d == ST_RUN);
      done     <= (state_d == ST_DONE);
      expired  <= expired_d;
    end
  end

  assign state     = state_q;
  assign pre_clear = stop || (state_q == ST_LOAD);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (pre_clear),
    .run   (enable),
    .gate  (!digits_zero),
    .tick  (tick),
    .cnt   (cnt)
  );

  // A paused count must resume exactly where it stopped.
  a_hold_freezes: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ST_HOLD && !stop) |=> (cnt == $past(cnt))
  );

endmodule

// File: tb/tb_countdown_ctrl.sv
// Self-checking bench for countdown_ctrl with directed scenarios and a randomized model check.
module tb_countdown_ctrl;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HOLD = 3, M_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic       dz_drv = 1'b0, use_digit = 1'b0;
  logic       digits_zero;
  logic       reconfig, enable, tick, expired, done;
  logic [2:0] state;
  logic       tick_q = 1'b0;
  int         digit = 0;
  int         checks = 0;
  int         errors = 0;

  int         m_mode = M_IDLE;
  int         m_phase = 0;
  logic       m_exp = 1'b0;

  always #5 clk = ~clk;

  countdown_ctrl #(.TICK_DIV(DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .digits_zero (digits_zero),
    .reconfig    (reconfig),
    .enable      (enable),
    .tick        (tick),
    .expired     (expired),
    .done        (done),
    .state       (state)
  );

  assign digits_zero = use_digit ? (digit == 0) : dz_drv;

  // Stand-in for one digitTimer digit: loads 9, decrements on a rising BorrowDown.
  always @(posedge clk) begin
    tick_q <= tick;
    if (reconfig) digit <= 9;
    else if (enable && tick && !tick_q && digit != 0) digit <= digit - 1;
  end

  // Reference model: controller mode plus the phase within the current tick period.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_phase = 0; m_exp = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (stop) begin
        m_mode = M_IDLE; m_phase = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (start) m_mode = M_LOAD;
          M_LOAD: begin m_mode = M_RUN; m_phase = 0; end
          M_RUN: begin
            m_phase = (m_phase + 1) % DIV;
            if (digits_zero) begin m_mode = M_DONE; m_exp = 1'b1; end
            else if (pause) m_mode = M_HOLD;
          end
          M_HOLD: if (start) m_mode = M_RUN;
          M_DONE: if (start) m_mode = M_LOAD;
          default: m_mode = M_IDLE;
        endcase
      end
    end
  end

  // Advance one clock, apply this cycle's inputs, and settle before sampling.
  task automatic cyc(input logic r, input logic s, input logic p, input logic t, input logic d);
    @(posedge clk);
    #1;
    rst = r; start = s; pause = p; stop = t; dz_drv = d;
    #3;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({reconfig, enable, tick, expired, done, state} !== 8'b0) begin
      errors++; $display("FAIL reset_initial got %b exp 00000000", {reconfig, enable, tick, expired, done, state});
    end
    cyc(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    checks++;
    if (enable !== 1'b1 || state !== 3'd2) begin
      errors++; $display("FAIL reset_prerun got en=%b st=%0d exp en=1 st=2", enable, state);
    end
    cyc(1, 0, 0, 0, 0);
    checks++;
    if ({reconfig, enable, tick, expired, done, state} !== 8'b0) begin
      errors++; $display("FAIL reset_midrun got %b exp 00000000", {reconfig, enable, tick, expired, done, state});
    end
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, 0, 0, 0);
      checks++;
      if (tick !== 1'b0 || state !== 3'd0) begin
        errors++; $display("FAIL reset_idle k=%0d got tick=%b st=%0d exp tick=0 st=0", k, tick, state);
      end
    end
  endtask

  task automatic test_cadence();
    logic exp_tick;
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= 16; k++) begin
      cyc(0, 0, 0, 0, 0);
      exp_tick = (k == 5) || (k == 9) || (k == 13);
      checks++;
      if (reconfig !== (k == 1) || tick !== exp_tick || state !== ((k == 1) ? 3'd1 : 3'd2)) begin
        errors++;
        $display("FAIL cadence k=%0d got rc=%b tick=%b st=%0d exp rc=%b tick=%b st=%0d",
                 k, reconfig, tick, state, (k == 1), exp_tick, (k == 1) ? 1 : 2);
      end
    end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL cadence_stop got st=%0d exp 0", state);
    end
  endtask

  // Runs a countdown already launched by the caller and checks 9 ticks then one expiry.
  task automatic run_countdown(input string name);
    int ticks, exp_cnt, exp_k;
    ticks = 0; exp_cnt = 0; exp_k = -1;
    for (int k = 1; k <= 100; k++) begin
      if (k > 1) cyc(0, 0, 0, 0, 0);
      if (tick === 1'b1) ticks++;
      if (expired === 1'b1) begin exp_cnt++; exp_k = k; end
      if (k == 2) begin
        checks++;
        if (digit !== 9) begin
          errors++; $display("FAIL %s_load got digit=%0d exp 9", name, digit);
        end
      end
      if (k > 39) begin
        checks++;
        if (done !== 1'b1 || tick !== 1'b0 || expired !== 1'b0 || digit !== 0) begin
          errors++;
          $display("FAIL %s_after k=%0d got done=%b tick=%b exp=%b digit=%0d exp 1 0 0 0",
                   name, k, done, tick, expired, digit);
        end
      end
    end
    checks++;
    if (ticks !== 9) begin
      errors++; $display("FAIL %s_ticks got %0d exp 9", name, ticks);
    end
    checks++;
    if (exp_cnt !== 1 || exp_k !== 39) begin
      errors++; $display("FAIL %s_expired got count=%0d at k=%0d exp count=1 at k=39", name, exp_cnt, exp_k);
    end
  endtask

  task automatic test_countdown();
    use_digit = 1'b1;
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (reconfig !== 1'b1 || state !== 3'd1) begin
      errors++; $display("FAIL countdown_load got rc=%b st=%0d exp rc=1 st=1", reconfig, state);
    end
    run_countdown("countdown");
  endtask

  task automatic test_restart();
    cyc(0, 1, 0, 0, 0);
    checks++;
    if (state !== 3'd4 || done !== 1'b1) begin
      errors++; $display("FAIL restart_pre got st=%0d done=%b exp st=4 done=1", state, done);
    end
    cyc(0, 0, 0, 0, 0);
    checks++;
    if (reconfig !== 1'b1 || state !== 3'd1) begin
      errors++; $display("FAIL restart_load got rc=%b st=%0d exp rc=1 st=1", reconfig, state);
    end
    run_countdown("restart");
    cyc(0, 0, 0, 1, 0);
    use_digit = 1'b0;
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_pause_collisions();
    logic s, p, t, d, exp_tick;
    int   exp_st;
    cyc(0, 1, 0, 0, 0);
    for (int k = 1; k <= 53; k++) begin
      s = (k == 34) || (k == 42) || (k == 47) || (k == 52);
      p = (k == 3) || (k == 40);
      t = (k == 52);
      d = (k >= 10 && k <= 15) || (k == 50);
      cyc(0, s, p, t, d);
      exp_tick = (k == 36) || (k == 40) || (k == 46);
      if (k == 1) exp_st = 1;
      else if (k <= 3) exp_st = 2;
      else if (k <= 34) exp_st = 3;
      else if (k <= 40) exp_st = 2;
      else if (k <= 42) exp_st = 3;
      else if (k <= 50) exp_st = 2;
      else if (k <= 52) exp_st = 4;
      else exp_st = 0;
      checks++;
      if (state !== 3'(exp_st) || tick !== exp_tick || expired !== (k == 51) || reconfig !== (k == 1)) begin
        errors++;
        $display("FAIL pause k=%0d got st=%0d tick=%b exp=%b rc=%b exp st=%0d tick=%b exp=%b rc=%b",
                 k, state, tick, expired, reconfig, exp_st, exp_tick, (k == 51), (k == 1));
      end
    end
  endtask

  task automatic test_random();
    logic       r, s, p, t, d;
    logic [7:0] got, want;
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 11) == 0);
      t = ($urandom_range(0, 39) == 0);
      d = ($urandom_range(0, 19) == 0);
      cyc(r, s, p, t, d);
      got  = {state, reconfig, enable, tick, expired, done};
      want = {3'(m_mode), (m_mode == M_LOAD), (m_mode == M_RUN),
              (m_mode == M_RUN && m_phase == DIV - 1 && !digits_zero), m_exp, (m_mode == M_DONE)};
      checks++;
      if (got !== want) begin
        errors++;
        if (errors < 20) $display("FAIL random k=%0d got %b exp %b", k, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cadence();
    test_countdown();
    test_restart();
    test_pause_collisions();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
